// File: rtl/status_cond_if.sv
// Flag/condition bus between the pipeline control (EXE/ID stages, stall logic)
// and the status/condition unit. The master drives stage information; the
// slave returns the architectural flags, the condition verdict and statistics.
interface status_cond_if #(
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             flush;
  logic             exe_valid;
  logic             exe_s;
  logic [3:0]       alu_flags;
  logic             id_valid;
  logic [3:0]       id_cond;
  logic             cnt_clr;
  logic [3:0]       status_out;
  logic [3:0]       eff_flags;
  logic             cond_pass;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output freeze, flush, exe_valid, exe_s, alu_flags,
    output id_valid, id_cond, cnt_clr,
    input  status_out, eff_flags, cond_pass, pass_cnt, fail_cnt
  );

  modport slave (
    input  freeze, flush, exe_valid, exe_s, alu_flags,
    input  id_valid, id_cond, cnt_clr,
    output status_out, eff_flags, cond_pass, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/status_cond_unit.sv
// NZCV status register with EXE->ID flag forwarding, ARM condition-code
// evaluation for the ID instruction, and saturating pass/fail counters.
module status_cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  status_cond_if.slave bus
);

  logic [3:0]       status_d, status_q;
  logic [CNT_W-1:0] pass_cnt_d, pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_d, fail_cnt_q;
  logic             wr;
  logic             fwd;
  logic [3:0]       eff_flags;
  logic             cond_pass;

  // Condition field decode against {N,Z,C,V}.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt) return cnt;
    return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Forward/write qualification, effective flags and the condition verdict.
  // Forwarding ignores freeze so a stalled flag-setter is still visible to ID.
  always_comb begin
    fwd       = bus.exe_valid & bus.exe_s & ~bus.flush;
    wr        = fwd & ~bus.freeze;
    eff_flags = fwd ? bus.alu_flags : status_q;
    cond_pass = cond_eval(bus.id_cond, eff_flags);
  end

  // Next-state for the status register and the statistics counters.
  // cnt_clr beats both an increment and freeze; rst is applied in the flop block.
  always_comb begin
    status_d   = status_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (wr) status_d = bus.alu_flags;
    if (bus.cnt_clr) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else if (bus.id_valid && !bus.freeze) begin
      if (cond_pass) pass_cnt_d = sat_inc(pass_cnt_q);
      else           fail_cnt_d = sat_inc(fail_cnt_q);
    end
  end

  // State registers; reset drops any in-flight flag write.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= 4'b0000;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      status_q   <= status_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign bus.status_out = status_q;
  assign bus.eff_flags  = eff_flags;
  assign bus.cond_pass  = cond_pass;
  assign bus.pass_cnt   = pass_cnt_q;
  assign bus.fail_cnt   = fail_cnt_q;

endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Consumer side of the ALU flag interface.
- Holds the architectural NZCV status register, which the ALU writes when a flag-setting instruction completes in EXE, and drives the ALU's Status input.
- Evaluates the 4-bit ARM condition field of the instruction in ID against the current flags. Flags produced in EXE in the same cycle are forwarded into that evaluation.
- Keeps saturating pass/fail counters for predicated-execution statistics.

Parameters:
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- freeze  in  1  pipeline stall; no register or counter state changes
- flush  in  1  squash the instruction currently in EXE
- exe_valid  in  1  EXE stage holds a real instruction
- exe_s  in  1  S bit of the EXE instruction (instruction updates flags)
- alu_flags  in  4  ALU Flags output {N,Z,C,V} = [3:0]
- id_valid  in  1  ID stage holds a real instruction
- id_cond  in  4  condition field of the ID instruction
- status_out  out  4  registered NZCV; feeds the ALU Status input (C_in = status_out[1])
- eff_flags  out  4  flags used for the condition check (forwarded or registered)
- cond_pass  out  1  ID instruction may execute
- cnt_clr  in  1  clear both counters
- pass_cnt  out  CNT_W  count of evaluated instructions that passed
- fail_cnt  out  CNT_W  count of evaluated instructions that failed

Behaviour:
- Reset: status_out = 4'b0000, pass_cnt = 0, fail_cnt = 0.
  - Combinational outputs follow from zero flags: eff_flags = 0 when no forwarding, cond_pass per id_cond.
- Write enable: wr = exe_valid & exe_s & ~flush & ~freeze.
  - At the clock edge, status_out <= alu_flags when wr = 1; otherwise hold.
  - Status update latency: 1 cycle after EXE.
- Forwarding (combinational): fwd = exe_valid & exe_s & ~flush.
  - eff_flags = fwd ? alu_flags : status_out.
  - fwd does not depend on freeze, so a stalled flag-setter in EXE still forwards.
- cond_pass is combinational from id_cond and eff_flags (N=[3], Z=[2], C=[1], V=[0]):
  - 0000 EQ Z; 0001 NE ~Z
  - 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N
  - 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 NV 0
  - cond_pass is independent of id_valid; the consumer gates it.
- Counters update when id_valid & ~freeze & ~rst:
  - cond_pass = 1: pass_cnt increments.
  - cond_pass = 0: fail_cnt increments.
  - Both counters saturate at all-ones and never wrap.
- cnt_clr zeroes both counters and overrides an increment in the same cycle. cnt_clr is honoured even when freeze = 1.
- Priority, highest first: rst > cnt_clr (counters only) > freeze > normal update.
- Reset mid-operation: all state returns to reset values on the next edge. Any in-flight flag write is lost.
- flush & exe_s in the same cycle: no write and no forwarding. eff_flags = status_out.
- Back-to-back flag setters: each cycle's alu_flags is written in turn, and the ID instruction always sees the youngest EXE producer.
- Target size: about 150 lines of RTL: register, forward mux, condition case, two counters.

Test Plan:
- Reset, then write with exe_valid=1, exe_s=1, alu_flags=4'b0100 -> status_out=0100 on the next cycle. With id_cond=0000 (EQ), cond_pass=1. With id_cond=0001, cond_pass=0.
- status_out=0000, EXE flag-setter with alu_flags=1000, id_cond=0100 (MI) in the same cycle -> eff_flags=1000, cond_pass=1 in that cycle (forwarding).
- Same stimulus with flush=1 -> eff_flags=0000, cond_pass=0, and status_out stays 0000 after the edge.
- freeze=1 for 3 cycles with a flag-setter alu_flags=0010 and id_valid=1 -> status_out and both counters unchanged. eff_flags=0010 throughout. On the first unfrozen edge, status_out=0010.
- Sweep all 16 id_cond values against all 16 flag values -> cond_pass matches the condition table (256 checks). id_cond=1111 always gives cond_pass=0.
- CNT_W=4: 17 passing id_valid cycles -> pass_cnt=15 (saturated). Then cnt_clr together with a passing instruction -> pass_cnt=0.
